// File: rtl/alu_pkg.sv
// Shared constants for the alu result stage: default data width,
// buffer state encoding and stored entry width.
package alu_pkg;

    localparam int BIT_DEFAULT = 32;
    localparam int ENTRY_W     = BIT_DEFAULT + 6;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative flag derivation for an alu result word.
module alu_flag_gen #(
    parameter int BIT = 32
) (
    input  logic [BIT-1:0] i_y,
    output logic           o_z,
    output logic           o_n
);

    assign o_z = (i_y == '0);
    assign o_n = i_y[BIT-1];

endmodule

// File: rtl/alu_result_stage.sv
// Registered alu output stage with two-entry skid buffer, flags and accept counter.
// Optional sticky carry (i_clr / o_sticky_c) is built when ALU_STICKY_C_EN is defined.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int BIT   = BIT_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [BIT-1:0]   i_data_y,
    input  logic             i_data_c,
    input  logic [2:0]       i_func,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [BIT-1:0]   o_data_y,
    output logic [2:0]       o_func,
    output logic             o_flag_c,
    output logic             o_flag_z,
    output logic             o_flag_n,
`ifdef ALU_STICKY_C_EN
    input  logic             i_clr,
    output logic             o_sticky_c,
`endif
    output logic [CNT_W-1:0] o_count
);

    localparam int EW = ENTRY_W - BIT_DEFAULT + BIT;

    logic [1:0]       state_q, state_d;
    logic [EW-1:0]    main_q, main_d;
    logic [EW-1:0]    skid_q, skid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [EW-1:0]    entry_in;
    logic             z_in, n_in;
    logic             accept, deliver;

    // Flags are computed at capture so the stored entry is self-contained.
    alu_flag_gen #(.BIT(BIT)) u_flag_gen (
        .i_y (i_data_y),
        .o_z (z_in),
        .o_n (n_in)
    );

    assign entry_in = {i_func, i_data_c, z_in, n_in, i_data_y};

    assign o_ready = (state_q != ST_FULL);
    assign o_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
    assign accept  = i_valid && o_ready;
    assign deliver = o_valid && i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = accept ? count_q + CNT_W'(1) : count_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = entry_in;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    main_d = entry_in;
                end else if (accept) begin
                    skid_d  = entry_in;
                    state_d = ST_FULL;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

    assign o_data_y = main_q[BIT-1:0];
    assign o_flag_n = main_q[BIT];
    assign o_flag_z = main_q[BIT+1];
    assign o_flag_c = main_q[BIT+2];
    assign o_func   = main_q[BIT+5:BIT+3];
    assign o_count  = count_q;

`ifdef ALU_STICKY_C_EN
    logic sticky_q, sticky_d;

    // A carry accept wins over a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        if (accept && i_data_c) begin
            sticky_d = 1'b1;
        end else if (i_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign o_sticky_c = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (default build).
module tb_alu_result_stage;

    logic        clk;
    logic        rstn;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] y_in;
    logic        c_in;
    logic [2:0]  func_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] y_out;
    logic [2:0]  func_out;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;
    logic [15:0] count;

    int tests;
    int fails;

    alu_result_stage #(.BIT(32), .CNT_W(16)) dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_valid  (valid_in),
        .o_ready  (ready_out),
        .i_data_y (y_in),
        .i_data_c (c_in),
        .i_func   (func_in),
        .o_valid  (valid_out),
        .i_ready  (ready_in),
        .o_data_y (y_out),
        .o_func   (func_out),
        .o_flag_c (flag_c),
        .o_flag_z (flag_z),
        .o_flag_n (flag_n),
        .o_count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] y, input logic c, input logic [2:0] f);
        valid_in = 1'b1;
        y_in     = y;
        c_in     = c;
        func_in  = f;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rstn     = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        y_in     = '0;
        c_in     = 1'b0;
        func_in  = '0;

        #12;
        check("rst_valid", valid_out, 1'b0);
        check("rst_ready", ready_out, 1'b1);
        check("rst_data",  y_out, 32'h0);
        check("rst_flags", {func_out, flag_c, flag_z, flag_n}, 6'h0);
        check("rst_count", count, 16'h0);
        rstn = 1'b1;
        tick();

        // Single accept, latency one cycle
        offer(32'h6666_6666, 1'b0, 3'd1);
        tick();
        valid_in = 1'b0;
        check("t1_valid", valid_out, 1'b1);
        check("t1_data",  y_out, 32'h6666_6666);
        check("t1_flags", {flag_c, flag_z, flag_n}, 3'b000);
        check("t1_func",  func_out, 3'd1);
        check("t1_count", count, 16'd1);

        // Carry and negative result, accepted while the first is delivered
        offer(32'hFFFF_FFFE, 1'b1, 3'd0);
        tick();
        check("t2_data",  y_out, 32'hFFFF_FFFE);
        check("t2_flags", {flag_c, flag_z, flag_n}, 3'b101);
        check("t2_count", count, 16'd2);

        // Zero result
        offer(32'h0, 1'b0, 3'd2);
        tick();
        check("t3_flags", {flag_c, flag_z, flag_n}, 3'b010);
        check("t3_func",  func_out, 3'd2);
        valid_in = 1'b0;
        tick();
        check("empty_valid", valid_out, 1'b0);
        check("empty_hold",  {func_out, flag_z}, {3'd2, 1'b1});

        // Back-pressure: A, B captured, C stalled
        ready_in = 1'b0;
        offer(32'd1, 1'b0, 3'd3);
        tick();
        check("bp_a_data",  y_out, 32'd1);
        check("bp_a_ready", ready_out, 1'b1);
        offer(32'd2, 1'b0, 3'd4);
        tick();
        check("bp_full_ready", ready_out, 1'b0);
        check("bp_full_data",  y_out, 32'd1);
        check("bp_full_count", count, 16'd5);
        offer(32'd3, 1'b0, 3'd5);
        tick();
        tick();
        check("bp_stall_data",  {func_out, y_out}, {3'd3, 32'd1});
        check("bp_stall_count", count, 16'd5);
        check("bp_stall_valid", valid_out, 1'b1);
        ready_in = 1'b1;
        tick();
        check("bp_b_data",  {func_out, y_out}, {3'd4, 32'd2});
        check("bp_b_ready", ready_out, 1'b1);
        check("bp_b_count", count, 16'd5);
        tick();
        check("bp_c_data",  {func_out, y_out}, {3'd5, 32'd3});
        check("bp_c_count", count, 16'd6);
        valid_in = 1'b0;
        tick();

        // Streaming: one result per cycle
        for (int i = 0; i < 8; i++) begin
            offer(32'd100 + 32'(i), 1'b0, 3'd6);
            tick();
            check("stream_data",  y_out, 32'd100 + 32'(i));
            check("stream_ready", {valid_out, ready_out}, 2'b11);
            check("stream_count", count, 16'd7 + 16'(i));
        end
        valid_in = 1'b0;
        tick();
        check("stream_end_valid", valid_out, 1'b0);

        // Counter wrap
        offer(32'h55, 1'b0, 3'd7);
        for (int i = 0; i < 65521; i++) begin
            tick();
        end
        check("wrap_max", count, 16'hFFFF);
        tick();
        check("wrap_zero", count, 16'h0);
        valid_in = 1'b0;
        tick();

        // Asynchronous reset while FULL
        ready_in = 1'b0;
        offer(32'hA, 1'b1, 3'd1);
        tick();
        offer(32'hB, 1'b0, 3'd2);
        tick();
        valid_in = 1'b0;
        check("full_ready", {valid_out, ready_out}, 2'b10);
        check("full_count", count, 16'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", valid_out, 1'b0);
        check("arst_count", count, 16'd0);
        check("arst_ready", ready_out, 1'b1);
        check("arst_data",  {flag_c, y_out}, 33'h0);
        #3;
        rstn = 1'b1;
        ready_in = 1'b1;
        tick();
        tick();
        check("arst_discard", valid_out, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
